// File: rtl/cva6_rvfi_serializer.sv
// Serializes multi-port RVFI retirement records into a single in-order stream,
// tagging each record with a 64-bit retirement order number and counting drops.

package config_pkg;
    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd1};

    // Minimal record carrying only the mandatory valid bit; real users override it.
    typedef struct packed {
        logic valid;
    } rvfi_instr_min_t;
endpackage

module cva6_rvfi_serializer #(
    parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
    parameter type rvfi_instr_t = config_pkg::rvfi_instr_min_t,
    parameter int unsigned Depth = 8
) (
    input  logic                                          clk_i,
    input  logic                                          rst_i,
    input  rvfi_instr_t [CVA6Cfg.NrCommitPorts-1:0]       rvfi_instr_i,
    output logic                                          trace_valid_o,
    input  logic                                          trace_ready_i,
    output rvfi_instr_t                                   trace_instr_o,
    output logic [63:0]                                   trace_order_o,
    output logic [$clog2(Depth):0]                        level_o,
    output logic                                          overflow_o,
    output logic [31:0]                                   drop_cnt_o,
    input  logic                                          clear_i
);

    localparam int unsigned NrPorts = CVA6Cfg.NrCommitPorts;
    localparam int unsigned AW      = $clog2(Depth);
    localparam int unsigned LW      = AW + 1;

    typedef logic [LW:0] cnt_t;

    rvfi_instr_t       mem_instr_q [Depth];
    logic [63:0]       mem_order_q [Depth];
    logic [AW-1:0]     wptr_q, rptr_q;
    logic [LW-1:0]     level_q;
    logic [63:0]       order_q;
    logic              overflow_q;
    logic [31:0]       drop_cnt_q;

    rvfi_instr_t       comp_instr [NrPorts];
    cnt_t              k, free, n_push, n_drop;
    logic              pop;
    logic [32:0]       drop_sum;

    // Compact valid records towards index 0, preserving port order.
    always_comb begin
        int unsigned j;
        j = 0;
        for (int unsigned p = 0; p < NrPorts; p++) begin
            comp_instr[p] = '0;
        end
        for (int unsigned p = 0; p < NrPorts; p++) begin
            if (rvfi_instr_i[p].valid) begin
                comp_instr[j]       = rvfi_instr_i[p];
                comp_instr[j].valid = 1'b1;
                j                   = j + 1;
            end
        end
        k        = cnt_t'(j);
        pop      = (level_q != '0) && trace_ready_i;
        free     = cnt_t'(Depth) - cnt_t'(level_q) + cnt_t'(pop);
        n_push   = (k < free) ? k : free;
        n_drop   = k - n_push;
        drop_sum = {1'b0, drop_cnt_q} + 33'(n_drop);
    end

    always_ff @(posedge clk_i) begin
        for (int unsigned i = 0; i < NrPorts; i++) begin
            if (cnt_t'(i) < n_push) begin
                mem_instr_q[wptr_q + AW'(i)] <= comp_instr[i];
                mem_order_q[wptr_q + AW'(i)] <= order_q + 64'(i);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q     <= '0;
            rptr_q     <= '0;
            level_q    <= '0;
            order_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wptr_q  <= wptr_q + n_push[AW-1:0];
            rptr_q  <= rptr_q + AW'(pop);
            level_q <= level_q + n_push[LW-1:0] - LW'(pop);
            order_q <= order_q + 64'(k);
            // A drop in the same cycle as clear restarts the count at this cycle's drops.
            if (n_drop != '0) begin
                overflow_q <= 1'b1;
                if (clear_i) begin
                    drop_cnt_q <= 32'(n_drop);
                end else begin
                    drop_cnt_q <= drop_sum[32] ? '1 : drop_sum[31:0];
                end
            end else if (clear_i) begin
                overflow_q <= 1'b0;
                drop_cnt_q <= '0;
            end
        end
    end

    assign trace_valid_o = (level_q != '0);
    assign trace_instr_o = trace_valid_o ? mem_instr_q[rptr_q] : '0;
    assign trace_order_o = trace_valid_o ? mem_order_q[rptr_q] : '0;
    assign level_o       = level_q;
    assign overflow_o    = overflow_q;
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_cva6_rvfi_serializer.sv
// Self-checking bench for cva6_rvfi_serializer: directed steps followed by
// random traffic, compared against a queue-based reference model.

module tb_cva6_rvfi_serializer;

    typedef struct packed {
        logic        valid;
        logic [31:0] insn;
        logic [63:0] pc;
    } rec_t;

    localparam int unsigned NP = 2;
    localparam int unsigned D  = 8;
    localparam config_pkg::cva6_cfg_t TbCfg = '{NrCommitPorts: NP};

    logic            clk = 1'b0;
    logic            rst;
    rec_t [NP-1:0]   in_r;
    logic            tvalid;
    logic            tready;
    rec_t            tinstr;
    logic [63:0]     torder;
    logic [3:0]      lvl;
    logic            ovf;
    logic [31:0]     dcnt;
    logic            clr;

    int tests = 0;
    int fails = 0;

    rec_t            mq[$];
    logic [63:0]     oq[$];
    logic [63:0]     m_order;
    logic [32:0]     m_drop;
    bit              m_ovf;

    cva6_rvfi_serializer #(
        .CVA6Cfg      (TbCfg),
        .rvfi_instr_t (rec_t),
        .Depth        (D)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .rvfi_instr_i  (in_r),
        .trace_valid_o (tvalid),
        .trace_ready_i (tready),
        .trace_instr_o (tinstr),
        .trace_order_o (torder),
        .level_o       (lvl),
        .overflow_o    (ovf),
        .drop_cnt_o    (dcnt),
        .clear_i       (clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t mk(input bit v, input logic [63:0] pc);
        rec_t r;
        r.valid = v;
        r.insn  = $urandom;
        r.pc    = pc;
        return r;
    endfunction

    task automatic model_reset();
        mq.delete();
        oq.delete();
        m_order = '0;
        m_drop  = '0;
        m_ovf   = 1'b0;
    endtask

    // Reference: pop first (frees a slot), then push valid records in port order.
    task automatic model_step(input bit rdy, input bit clear);
        int d;
        rec_t r;
        d = 0;
        if (mq.size() != 0 && rdy) begin
            void'(mq.pop_front());
            void'(oq.pop_front());
        end
        for (int p = 0; p < NP; p++) begin
            if (in_r[p].valid) begin
                if (mq.size() < D) begin
                    r = in_r[p];
                    mq.push_back(r);
                    oq.push_back(m_order);
                end else begin
                    d++;
                end
                m_order = m_order + 64'd1;
            end
        end
        if (d > 0) begin
            m_ovf  = 1'b1;
            m_drop = clear ? 33'(d) : m_drop + 33'(d);
            if (m_drop > 33'hFFFF_FFFF) m_drop = 33'hFFFF_FFFF;
        end else if (clear) begin
            m_ovf  = 1'b0;
            m_drop = '0;
        end
    endtask

    task automatic check_all();
        chk("valid", 128'(tvalid), 128'(mq.size() != 0));
        chk("level", 128'(lvl), 128'(mq.size()));
        chk("overflow", 128'(ovf), 128'(m_ovf));
        chk("drop_cnt", 128'(dcnt), 128'(m_drop[31:0]));
        if (mq.size() != 0) begin
            chk("pc", 128'(tinstr.pc), 128'(mq[0].pc));
            chk("insn", 128'(tinstr.insn), 128'(mq[0].insn));
            chk("instr_valid", 128'(tinstr.valid), 128'(1'b1));
            chk("order", 128'(torder), 128'(oq[0]));
        end else begin
            chk("empty_instr_zero", 128'(tinstr), 128'(0));
            chk("empty_order_zero", 128'(torder), 128'(0));
        end
    endtask

    task automatic step(input rec_t a, input rec_t b, input bit rdy, input bit clear);
        in_r[0] = a;
        in_r[1] = b;
        tready  = rdy;
        clr     = clear;
        @(posedge clk);
        model_step(rdy, clear);
        #1;
        in_r   = '0;
        tready = 1'b0;
        clr    = 1'b0;
        check_all();
    endtask

    initial begin
        rec_t z;
        z      = '0;
        rst    = 1'b1;
        in_r   = '0;
        tready = 1'b0;
        clr    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;

        // Single record, ready high: visible exactly one cycle later.
        step(mk(1, 64'h8000_0000), z, 1, 0);
        chk("first_pc", 128'(tinstr.pc), 128'(64'h8000_0000));
        chk("first_order", 128'(torder), 128'(0));
        step(z, z, 1, 0);
        chk("first_gone", 128'(tvalid), 128'(0));

        // Two ports in one cycle, then port 1 only, then port 0 only.
        step(mk(1, 64'h100), mk(1, 64'h104), 1, 0);
        step(z, z, 1, 0);
        step(z, mk(1, 64'h200), 1, 0);
        step(mk(1, 64'h204), z, 1, 0);
        step(z, z, 1, 0);
        step(z, z, 1, 0);

        // Overflow: 10 records into 8 slots with no pop.
        model_reset();
        rst = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(mk(1, 64'(32'h1000 + 8 * i)), mk(1, 64'(32'h1004 + 8 * i)), 0, 0);
        end
        chk("full_level", 128'(lvl), 128'(8));
        chk("full_ovf", 128'(ovf), 128'(1));
        chk("full_drop", 128'(dcnt), 128'(2));

        // Full with pop: one record accepted, level stays 8.
        step(mk(1, 64'h2000), z, 1, 0);
        chk("fullpop_level", 128'(lvl), 128'(8));
        chk("fullpop_drop", 128'(dcnt), 128'(2));

        // Clear coinciding with a one-record drop, then a lone clear.
        step(mk(1, 64'h3000), z, 0, 1);
        chk("clr_drop_ovf", 128'(ovf), 128'(1));
        chk("clr_drop_cnt", 128'(dcnt), 128'(1));
        step(z, z, 0, 1);
        chk("clr_ovf", 128'(ovf), 128'(0));
        chk("clr_cnt", 128'(dcnt), 128'(0));

        // Drain: orders 1..7 then 10.
        for (int i = 0; i < 9; i++) step(z, z, 1, 0);

        // Reset mid-stream with 5 entries queued.
        for (int i = 0; i < 3; i++) step(mk(1, 64'(32'h4000 + i)), mk(i < 2, 64'(32'h4100 + i)), 0, 0);
        chk("pre_rst_level", 128'(lvl), 128'(5));
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        chk("rst_valid", 128'(tvalid), 128'(0));
        chk("rst_level", 128'(lvl), 128'(0));
        chk("rst_instr", 128'(tinstr), 128'(0));
        chk("rst_order", 128'(torder), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        step(mk(1, 64'h5000), z, 1, 0);
        chk("post_rst_order", 128'(torder), 128'(0));
        step(z, z, 1, 0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(mk($urandom_range(0, 1), 64'($urandom)), mk($urandom_range(0, 1), 64'($urandom)),
                 $urandom_range(0, 3) != 0 && i % 64 < 48, $urandom_range(0, 15) == 0);
        end
        for (int i = 0; i < D + 1; i++) step(z, z, 1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
